// File: rtl/axis_mls_burst_gen.sv
// AXI4-Stream MLS burst source for the Red Pitaya DAC.
// Lane A carries the stretched +/-amp chip waveform; lane B carries a +amp burst marker.
module axis_mls_burst_gen #(
    parameter int DAC_DATA_WIDTH   = 14,
    parameter int AXIS_TDATA_WIDTH = 32
) (
    input  logic                        aclk,
    input  logic                        rst,
    input  logic [31:0]                 cfg_i,
    input  logic [12:0]                 amp_i,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        flag_o,
    output logic                        busy_o,
    output logic                        done_o
);
    localparam int LANE_WIDTH = AXIS_TDATA_WIDTH / 2;

    typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

    state_t      state;
    logic        start_q;
    logic        start_edge_q;
    logic [7:0]  div_q;
    logic [2:0]  rep_q;
    logic [2:0]  ord_q;
    logic [7:0]  gap_q;
    logic [12:0] amp_q;
    logic [11:0] lfsr;
    logic [7:0]  sample_cnt;
    logic [11:0] chip_cnt;
    logic [2:0]  rep_cnt;
    logic [7:0]  gap_cnt;
    logic        last_q;

    logic        start_bit;
    logic        srst_bit;
    logic        load;
    logic        feedback;
    logic        chip_bit;
    logic [11:0] chip_last_idx;
    logic        sample_last;
    logic        chip_last;
    logic        gap_last;
    logic        rep_last;
    logic        final_sample;
    logic [DAC_DATA_WIDTH-1:0] amp_pos;
    logic [DAC_DATA_WIDTH-1:0] amp_neg;
    logic [DAC_DATA_WIDTH-1:0] chip_value;
    logic [LANE_WIDTH-1:0]     lane_a;
    logic [LANE_WIDTH-1:0]     lane_b;
    logic                      unused_cfg;

    assign unused_cfg = ^cfg_i[31:24];
    assign start_bit  = cfg_i[14];
    assign srst_bit   = cfg_i[15];

    // The output register accepts a new sample whenever it is empty or being drained.
    assign load = ~m_axis_tvalid | m_axis_tready;

    always_comb begin
        feedback = 1'b0;
        case (ord_q)
            3'd0:    feedback = lfsr[4] ^ lfsr[2];
            3'd1:    feedback = lfsr[5] ^ lfsr[4];
            3'd2:    feedback = lfsr[6] ^ lfsr[5];
            3'd3:    feedback = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
            3'd4:    feedback = lfsr[8] ^ lfsr[4];
            3'd5:    feedback = lfsr[9] ^ lfsr[6];
            3'd6:    feedback = lfsr[10] ^ lfsr[8];
            default: feedback = lfsr[11] ^ lfsr[10] ^ lfsr[9] ^ lfsr[3];
        endcase
    end

    assign chip_bit      = lfsr[4'(ord_q) + 4'd4];
    assign chip_last_idx = 12'((13'd1 << (4'(ord_q) + 4'd5)) - 13'd2);
    assign sample_last   = (sample_cnt == div_q);
    assign chip_last     = (chip_cnt == chip_last_idx);
    assign gap_last      = (gap_cnt == 8'(gap_q - 8'd1));
    assign rep_last      = (rep_cnt == rep_q);
    assign final_sample  = sample_last && rep_last &&
                           ((state == RUN && chip_last && gap_q == 8'd0) ||
                            (state == GAP && gap_last));

    assign amp_pos    = DAC_DATA_WIDTH'(amp_q);
    assign amp_neg    = -amp_pos;
    assign chip_value = chip_bit ? amp_pos : amp_neg;
    assign lane_a     = {{(LANE_WIDTH-DAC_DATA_WIDTH){chip_value[DAC_DATA_WIDTH-1]}}, chip_value};
    assign lane_b     = LANE_WIDTH'(amp_q);

    // FSM state, counters, LFSR and registered outputs all advance together on load.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            start_q       <= 1'b0;
            start_edge_q  <= 1'b0;
            div_q         <= '0;
            rep_q         <= '0;
            ord_q         <= '0;
            gap_q         <= '0;
            amp_q         <= '0;
            lfsr          <= '1;
            sample_cnt    <= '0;
            chip_cnt      <= '0;
            rep_cnt       <= '0;
            gap_cnt       <= '0;
            last_q        <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            flag_o        <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
        end else begin
            m_axis_tvalid <= 1'b1;
            start_q       <= start_bit;
            start_edge_q  <= 1'b0;
            if (srst_bit) begin
                state        <= IDLE;
                lfsr         <= '1;
                sample_cnt   <= '0;
                chip_cnt     <= '0;
                rep_cnt      <= '0;
                gap_cnt      <= '0;
                last_q       <= 1'b0;
                m_axis_tdata <= '0;
                flag_o       <= 1'b0;
                busy_o       <= 1'b0;
                done_o       <= 1'b0;
            end else begin
                done_o <= m_axis_tvalid & m_axis_tready & last_q;
                case (state)
                    IDLE: begin
                        lfsr       <= '1;
                        sample_cnt <= '0;
                        chip_cnt   <= '0;
                        rep_cnt    <= '0;
                        gap_cnt    <= '0;
                        if (start_edge_q) begin
                            state <= RUN;
                        end
                        if (start_bit && !start_q) begin
                            start_edge_q <= 1'b1;
                            div_q        <= cfg_i[7:0];
                            rep_q        <= cfg_i[10:8];
                            ord_q        <= cfg_i[13:11];
                            gap_q        <= cfg_i[23:16];
                            amp_q        <= amp_i;
                        end
                        if (load) begin
                            m_axis_tdata <= '0;
                            flag_o       <= 1'b0;
                            busy_o       <= 1'b0;
                            last_q       <= 1'b0;
                        end
                    end
                    RUN: begin
                        if (load) begin
                            m_axis_tdata <= {lane_b, lane_a};
                            flag_o       <= 1'b1;
                            busy_o       <= 1'b1;
                            last_q       <= final_sample;
                            if (!sample_last) begin
                                sample_cnt <= sample_cnt + 8'd1;
                            end else begin
                                sample_cnt <= '0;
                                if (!chip_last) begin
                                    chip_cnt <= chip_cnt + 12'd1;
                                    lfsr     <= {lfsr[10:0], feedback};
                                end else begin
                                    chip_cnt <= '0;
                                    lfsr     <= '1;
                                    if (gap_q != 8'd0) begin
                                        state   <= GAP;
                                        gap_cnt <= '0;
                                    end else if (!rep_last) begin
                                        rep_cnt <= rep_cnt + 3'd1;
                                    end else begin
                                        state   <= IDLE;
                                        rep_cnt <= '0;
                                    end
                                end
                            end
                        end
                    end
                    GAP: begin
                        if (load) begin
                            m_axis_tdata <= '0;
                            flag_o       <= 1'b0;
                            busy_o       <= 1'b1;
                            last_q       <= final_sample;
                            if (!sample_last) begin
                                sample_cnt <= sample_cnt + 8'd1;
                            end else begin
                                sample_cnt <= '0;
                                if (!gap_last) begin
                                    gap_cnt <= gap_cnt + 8'd1;
                                end else begin
                                    gap_cnt <= '0;
                                    if (!rep_last) begin
                                        rep_cnt <= rep_cnt + 3'd1;
                                        state   <= RUN;
                                    end else begin
                                        rep_cnt <= '0;
                                        state   <= IDLE;
                                    end
                                end
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_axis_mls_burst_gen.sv
// Randomized self-checking bench for axis_mls_burst_gen against a recurrence-based MLS model.
module tb_axis_mls_burst_gen;
    logic        aclk = 1'b0;
    logic        rst;
    logic [31:0] cfg_i;
    logic [12:0] amp_i;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        flag_o;
    logic        busy_o;
    logic        done_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 aclk = ~aclk;

    axis_mls_burst_gen #(.DAC_DATA_WIDTH(14), .AXIS_TDATA_WIDTH(32)) dut (
        .aclk          (aclk),
        .rst           (rst),
        .cfg_i         (cfg_i),
        .amp_i         (amp_i),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .flag_o        (flag_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    function automatic logic [31:0] make_cfg(int div, int rep, int ord, bit start, bit srst, int gap);
        return {8'hA5, 8'(gap), srst, start, 3'(ord), 3'(rep), 8'(div)};
    endfunction

    // Expected accepted-sample stream: x[k+N] = XOR over taps t of x[k+N-t], seeded with N ones.
    task automatic build_model(input int ord, input int div, input int rep, input int gap,
                               input int amp, output logic [31:0] exp_q[$]);
        int n;
        int len;
        int taps[$];
        bit x[];
        bit fb;
        logic [15:0] pos;
        logic [15:0] neg;
        n   = ord + 5;
        len = (1 << n) - 1;
        case (n)
            5:       taps = '{5, 3};
            6:       taps = '{6, 5};
            7:       taps = '{7, 6};
            8:       taps = '{8, 6, 5, 4};
            9:       taps = '{9, 5};
            10:      taps = '{10, 7};
            11:      taps = '{11, 9};
            default: taps = '{12, 11, 10, 4};
        endcase
        x = new[len + n];
        for (int k = 0; k < n; k++) x[k] = 1'b1;
        for (int k = 0; k < len; k++) begin
            fb = 1'b0;
            foreach (taps[i]) fb ^= x[k + n - taps[i]];
            x[k + n] = fb;
        end
        pos = 16'(amp);
        neg = 16'(-amp);
        exp_q = {};
        for (int p = 0; p <= rep; p++) begin
            for (int c = 0; c < len; c++)
                for (int s = 0; s <= div; s++)
                    exp_q.push_back({pos, x[c] ? pos : neg});
            for (int g = 0; g < gap * (div + 1); g++)
                exp_q.push_back(32'd0);
        end
    endtask

    function automatic int first_diff(input logic [31:0] a[$], input logic [31:0] b[$]);
        int m;
        m = (a.size() < b.size()) ? a.size() : b.size();
        for (int i = 0; i < m; i++) if (a[i] !== b[i]) return i;
        if (a.size() != b.size()) return m;
        return -1;
    endfunction

    // Starts a burst, records every accepted busy sample and watches done_o until shortly after it.
    task automatic run_burst(input int ord, input int div, input int rep, input int gap, input int amp,
                             input int ready_pct, input int chg_at, input int new_amp, input int new_ord,
                             output logic [31:0] got[$], output int flag_cnt, output int done_cnt,
                             output int first_flag, output int at_done, output int stall_bad,
                             output bit done_clean, output bit timeout);
        logic [31:0] prev_data;
        bit          prev_stall;
        int          max_cycles;
        int          post;
        got = {};
        flag_cnt = 0; done_cnt = 0; first_flag = -1; at_done = -1; stall_bad = 0;
        done_clean = 1'b1; timeout = 1'b0; post = -1;
        prev_stall = 1'b0; prev_data = '0;
        max_cycles = (rep + 1) * ((1 << (ord + 5)) - 1 + gap) * (div + 1) * 4 + 64;
        @(negedge aclk);
        cfg_i = make_cfg(div, rep, ord, 1'b1, 1'b0, gap);
        amp_i = 13'(amp);
        m_axis_tready = ($urandom_range(99) < ready_pct);
        for (int c = 0; c < max_cycles; c++) begin
            @(negedge aclk);
            if (prev_stall && m_axis_tdata !== prev_data) stall_bad++;
            if (done_o === 1'b1) begin
                done_cnt++;
                if (at_done < 0) at_done = got.size();
                if (m_axis_tdata !== 32'd0 || flag_o !== 1'b0 || busy_o !== 1'b0) done_clean = 1'b0;
                if (post < 0) post = c + 4;
            end
            if (flag_o === 1'b1 && first_flag < 0) first_flag = c;
            if (c == chg_at) begin
                cfg_i = make_cfg(div, rep, new_ord, 1'b1, 1'b0, gap);
                amp_i = 13'(new_amp);
            end
            m_axis_tready = ($urandom_range(99) < ready_pct);
            if (m_axis_tready && m_axis_tvalid === 1'b1 && busy_o === 1'b1) begin
                got.push_back(m_axis_tdata);
                if (flag_o === 1'b1) flag_cnt++;
            end
            prev_stall = !m_axis_tready && busy_o === 1'b1;
            prev_data  = m_axis_tdata;
            if (c == post) break;
        end
        if (post < 0) timeout = 1'b1;
        cfg_i = make_cfg(div, rep, ord, 1'b0, 1'b0, gap);
        m_axis_tready = 1'b1;
        @(negedge aclk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cfg_i = make_cfg(0, 0, 0, 1'b0, 1'b0, 0);
        amp_i = '0;
        m_axis_tready = 1'b1;
        #1;
        repeat (3) @(negedge aclk);
        n_cmp++;
        if ({m_axis_tdata, m_axis_tvalid, flag_o, busy_o, done_o} !== 36'd0) begin
            n_bad++;
            $display("[TB] FAIL reset_outputs: got tdata=%h tvalid=%b flag=%b busy=%b done=%b, want all 0",
                     m_axis_tdata, m_axis_tvalid, flag_o, busy_o, done_o);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (m_axis_tvalid !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL release_tvalid_early: got %b, want 0", m_axis_tvalid);
        end
        @(negedge aclk);
        n_cmp++;
        if (m_axis_tvalid !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL release_tvalid: got %b, want 1", m_axis_tvalid);
        end
        n_cmp++;
        if ({m_axis_tdata, flag_o, busy_o, done_o} !== 35'd0) begin
            n_bad++;
            $display("[TB] FAIL idle_outputs: got tdata=%h flag=%b busy=%b done=%b, want 0",
                     m_axis_tdata, flag_o, busy_o, done_o);
        end
    endtask

    task automatic test_minimal();
        logic [31:0] got[$];
        logic [31:0] exp_q[$];
        logic [31:0] first;
        int flag_cnt, done_cnt, first_flag, at_done, stall_bad, d, pos_cnt, neg_cnt;
        bit clean, tmo;
        build_model(0, 0, 0, 0, 4000, exp_q);
        run_burst(0, 0, 0, 0, 4000, 100, -1, 0, 0, got, flag_cnt, done_cnt, first_flag, at_done,
                  stall_bad, clean, tmo);
        n_cmp++;
        if (tmo) begin n_bad++; $display("[TB] FAIL min_timeout: done_o never seen"); end
        n_cmp++;
        if (got.size() != 31) begin
            n_bad++; $display("[TB] FAIL min_length: got %0d samples, want 31", got.size());
        end
        d = first_diff(got, exp_q);
        n_cmp++;
        if (d != -1) begin
            n_bad++;
            $display("[TB] FAIL min_sequence: first difference at sample %0d (got %0d/%0d samples)",
                     d, got.size(), exp_q.size());
        end
        first = (got.size() > 0) ? got[0] : 32'hDEAD_BEEF;
        n_cmp++;
        if (first !== 32'h0FA0_0FA0) begin
            n_bad++; $display("[TB] FAIL min_first_chip: got %h, want 0fa00fa0", first);
        end
        pos_cnt = 0; neg_cnt = 0;
        foreach (got[i]) begin
            if (got[i] === 32'h0FA0_0FA0) pos_cnt++;
            if (got[i] === 32'h0FA0_F060) neg_cnt++;
        end
        n_cmp++;
        if (pos_cnt != 16 || neg_cnt != 15) begin
            n_bad++;
            $display("[TB] FAIL min_balance: got %0d plus / %0d minus, want 16 / 15", pos_cnt, neg_cnt);
        end
        n_cmp++;
        if (flag_cnt != 31) begin n_bad++; $display("[TB] FAIL min_flag: got %0d, want 31", flag_cnt); end
        n_cmp++;
        if (done_cnt != 1) begin n_bad++; $display("[TB] FAIL min_done: got %0d pulses, want 1", done_cnt); end
        n_cmp++;
        if (!clean || at_done != 31) begin
            n_bad++;
            $display("[TB] FAIL min_done_state: clean=%0b after %0d samples, want clean=1 after 31",
                     clean, at_done);
        end
        n_cmp++;
        if (first_flag != 2) begin
            n_bad++; $display("[TB] FAIL min_latency: got %0d cycles, want 2", first_flag);
        end
    endtask

    task automatic test_stretch_gap();
        logic [31:0] got[$];
        logic [31:0] exp_q[$];
        int flag_cnt, done_cnt, first_flag, at_done, stall_bad, d, amp;
        bit clean, tmo;
        amp = $urandom_range(8191);
        build_model(0, 3, 1, 2, amp, exp_q);
        run_burst(0, 3, 1, 2, amp, 100, -1, 0, 0, got, flag_cnt, done_cnt, first_flag, at_done,
                  stall_bad, clean, tmo);
        n_cmp++;
        if (tmo || got.size() != 264) begin
            n_bad++; $display("[TB] FAIL gap_length: got %0d samples (timeout=%0b), want 264", got.size(), tmo);
        end
        d = first_diff(got, exp_q);
        n_cmp++;
        if (d != -1) begin n_bad++; $display("[TB] FAIL gap_sequence: first difference at %0d, amp=%0d", d, amp); end
        n_cmp++;
        if (flag_cnt != 248) begin n_bad++; $display("[TB] FAIL gap_flag: got %0d, want 248", flag_cnt); end
        n_cmp++;
        if (done_cnt != 1 || !clean) begin
            n_bad++; $display("[TB] FAIL gap_done: got %0d pulses clean=%0b, want 1 clean", done_cnt, clean);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] got[$];
        logic [31:0] exp_q[$];
        int flag_cnt, done_cnt, first_flag, at_done, stall_bad, d, amp;
        bit clean, tmo;
        amp = $urandom_range(1, 8191);
        build_model(3, 0, 0, 0, amp, exp_q);
        run_burst(3, 0, 0, 0, amp, 50, -1, 0, 0, got, flag_cnt, done_cnt, first_flag, at_done,
                  stall_bad, clean, tmo);
        d = first_diff(got, exp_q);
        n_cmp++;
        if (tmo || d != -1) begin
            n_bad++; $display("[TB] FAIL bp_sequence: first difference at %0d (timeout=%0b)", d, tmo);
        end
        n_cmp++;
        if (stall_bad != 0) begin n_bad++; $display("[TB] FAIL bp_stable: %0d changes under stall, want 0", stall_bad); end
        n_cmp++;
        if (done_cnt != 1 || at_done != 255) begin
            n_bad++;
            $display("[TB] FAIL bp_done: got %0d pulses after %0d accepts, want 1 after 255", done_cnt, at_done);
        end
    endtask

    task automatic test_abort_restart();
        logic [31:0] got[$];
        logic [31:0] exp_q[$];
        int flag_cnt, done_cnt, first_flag, at_done, stall_bad, d, runs, busy_seen, dones;
        bit clean, tmo;
        runs = 0; busy_seen = 0; dones = 0;
        @(negedge aclk);
        cfg_i = make_cfg(0, 0, 7, 1'b1, 1'b0, 0);
        amp_i = 13'd1234;
        for (int c = 0; c < 200 && runs < 40; c++) begin
            @(negedge aclk);
            if (flag_o === 1'b1) runs++;
        end
        n_cmp++;
        if (runs != 40) begin n_bad++; $display("[TB] FAIL abort_reach: got %0d run samples, want 40", runs); end
        cfg_i = make_cfg(0, 0, 7, 1'b1, 1'b1, 0);
        @(negedge aclk);
        n_cmp++;
        if ({m_axis_tdata, flag_o, busy_o, done_o} !== 35'd0) begin
            n_bad++;
            $display("[TB] FAIL abort_idle: got tdata=%h flag=%b busy=%b done=%b, want 0",
                     m_axis_tdata, flag_o, busy_o, done_o);
        end
        cfg_i = make_cfg(0, 0, 7, 1'b1, 1'b0, 0);
        repeat (30) begin
            @(negedge aclk);
            if (busy_o !== 1'b0) busy_seen++;
            if (done_o !== 1'b0) dones++;
        end
        n_cmp++;
        if (busy_seen != 0 || dones != 0) begin
            n_bad++;
            $display("[TB] FAIL abort_hold_start: busy %0d cycles, done %0d, want 0 and 0", busy_seen, dones);
        end
        cfg_i = make_cfg(0, 0, 7, 1'b0, 1'b0, 0);
        @(negedge aclk);
        build_model(7, 0, 0, 0, 1234, exp_q);
        run_burst(7, 0, 0, 0, 1234, 100, -1, 0, 0, got, flag_cnt, done_cnt, first_flag, at_done,
                  stall_bad, clean, tmo);
        d = first_diff(got, exp_q);
        n_cmp++;
        if (tmo || d != -1 || done_cnt != 1) begin
            n_bad++;
            $display("[TB] FAIL abort_restart: diff at %0d, done %0d, timeout=%0b, want -1, 1, 0", d, done_cnt, tmo);
        end
    endtask

    task automatic test_config_isolation();
        logic [31:0] got[$];
        logic [31:0] exp_q[$];
        int flag_cnt, done_cnt, first_flag, at_done, stall_bad, d;
        bit clean, tmo;
        build_model(1, 1, 0, 1, 2500, exp_q);
        run_burst(1, 1, 0, 1, 2500, 100, 10, 6000, 0, got, flag_cnt, done_cnt, first_flag, at_done,
                  stall_bad, clean, tmo);
        d = first_diff(got, exp_q);
        n_cmp++;
        if (tmo || d != -1) begin
            n_bad++; $display("[TB] FAIL iso_midburst: first difference at %0d (timeout=%0b), want none", d, tmo);
        end
        build_model(0, 1, 0, 1, 6000, exp_q);
        run_burst(0, 1, 0, 1, 6000, 100, -1, 0, 0, got, flag_cnt, done_cnt, first_flag, at_done,
                  stall_bad, clean, tmo);
        d = first_diff(got, exp_q);
        n_cmp++;
        if (tmo || d != -1) begin
            n_bad++; $display("[TB] FAIL iso_next_burst: first difference at %0d (timeout=%0b), want none", d, tmo);
        end
    endtask

    task automatic test_async_reset();
        int dones;
        dones = 0;
        @(negedge aclk);
        cfg_i = make_cfg(1, 0, 2, 1'b1, 1'b0, 0);
        amp_i = 13'd777;
        repeat (20) @(negedge aclk);
        n_cmp++;
        if (busy_o !== 1'b1) begin n_bad++; $display("[TB] FAIL async_running: busy=%b, want 1", busy_o); end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({m_axis_tdata, m_axis_tvalid, flag_o, busy_o, done_o} !== 36'd0) begin
            n_bad++;
            $display("[TB] FAIL async_clear: got tdata=%h tvalid=%b flag=%b busy=%b done=%b, want all 0",
                     m_axis_tdata, m_axis_tvalid, flag_o, busy_o, done_o);
        end
        cfg_i = make_cfg(1, 0, 2, 1'b0, 1'b0, 0);
        @(negedge aclk);
        rst = 1'b0;
        @(negedge aclk);
        n_cmp++;
        if (m_axis_tvalid !== 1'b1 || busy_o !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL async_release: tvalid=%b busy=%b, want 1 and 0", m_axis_tvalid, busy_o);
        end
        repeat (10) begin
            @(negedge aclk);
            if (done_o !== 1'b0) dones++;
        end
        n_cmp++;
        if (dones != 0) begin n_bad++; $display("[TB] FAIL async_no_done: got %0d pulses, want 0", dones); end
    endtask

    task automatic test_extremes();
        logic [31:0] got[$];
        logic [31:0] exp_q[$];
        logic [31:0] first;
        int flag_cnt, done_cnt, first_flag, at_done, stall_bad, d, neg_cnt;
        bit clean, tmo;
        build_model(0, 0, 0, 0, 8191, exp_q);
        run_burst(0, 0, 0, 0, 8191, 100, -1, 0, 0, got, flag_cnt, done_cnt, first_flag, at_done,
                  stall_bad, clean, tmo);
        first = (got.size() > 0) ? got[0] : 32'hDEAD_BEEF;
        neg_cnt = 0;
        foreach (got[i]) if (got[i] === 32'h1FFF_E001) neg_cnt++;
        n_cmp++;
        if (first !== 32'h1FFF_1FFF || neg_cnt != 15) begin
            n_bad++;
            $display("[TB] FAIL max_amp: first=%h minus=%0d, want 1fff1fff and 15", first, neg_cnt);
        end
        d = first_diff(got, exp_q);
        n_cmp++;
        if (tmo || d != -1) begin n_bad++; $display("[TB] FAIL max_sequence: first difference at %0d", d); end
        build_model(0, 0, 0, 0, 0, exp_q);
        run_burst(0, 0, 0, 0, 0, 100, -1, 0, 0, got, flag_cnt, done_cnt, first_flag, at_done,
                  stall_bad, clean, tmo);
        d = first_diff(got, exp_q);
        n_cmp++;
        if (tmo || d != -1 || flag_cnt != 31) begin
            n_bad++;
            $display("[TB] FAIL zero_amp: diff at %0d, flag %0d, want -1 and 31", d, flag_cnt);
        end
    endtask

    task automatic test_random();
        logic [31:0] got[$];
        logic [31:0] exp_q[$];
        int flag_cnt, done_cnt, first_flag, at_done, stall_bad, d, ord, div, rep, gap, amp;
        bit clean, tmo;
        for (int it = 0; it < 3; it++) begin
            ord = $urandom_range(3); div = $urandom_range(3); rep = $urandom_range(2);
            gap = $urandom_range(3); amp = $urandom_range(8191);
            build_model(ord, div, rep, gap, amp, exp_q);
            run_burst(ord, div, rep, gap, amp, 70, -1, 0, 0, got, flag_cnt, done_cnt, first_flag,
                      at_done, stall_bad, clean, tmo);
            d = first_diff(got, exp_q);
            n_cmp++;
            if (tmo || d != -1 || done_cnt != 1 || stall_bad != 0 || at_done != exp_q.size()) begin
                n_bad++;
                $display("[TB] FAIL random_%0d: ord=%0d div=%0d rep=%0d gap=%0d amp=%0d diff=%0d done=%0d stall=%0d timeout=%0b, want diff -1 done 1 stall 0",
                         it, ord, div, rep, gap, amp, d, done_cnt, stall_bad, tmo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_minimal();
        test_stretch_gap();
        test_backpressure();
        test_abort_restart();
        test_config_isolation();
        test_async_reset();
        test_extremes();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
